// File: rtl/edge_axis_packer.sv
// Edge-pixel packer: gathers 8-bit binary edge pixels four to a 32-bit word
// and queues the words in a first-word-fall-through FIFO that feeds an
// AXI4-Stream master (TKEEP for short line tails, TLAST per line, TUSER at
// start of frame).
module edge_axis_packer #(
  parameter int DEPTH       = 16,
  parameter int FRAME_LINES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        pix_last,
  output logic        pix_ready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        ovf,
  input  logic        clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [LW-1:0] LAST_LINE = LW'(FRAME_LINES - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);

  // FIFO entry layout: {tuser, tlast, tkeep[3:0], tdata[31:0]}
  logic [37:0]   r_mem [DEPTH];
  logic [31:0]   r_hold;
  logic [1:0]    r_idx;
  logic [AW:0]   r_cnt;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_line;
  logic          r_sof;
  logic          r_ovf;

  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_word;
  logic [3:0]    w_keep;
  logic [37:0]   w_head;

  // Readiness depends only on the registered fill level, never on tready.
  assign pix_ready = (r_cnt < DEPTH_C);
  assign w_accept  = pix_valid && pix_ready;
  assign w_push    = w_accept && ((r_idx == 2'd3) || pix_last);
  assign w_pop     = m_axis_tvalid && m_axis_tready;

  // Assemble the completing word: earlier lanes from the holding register,
  // the current lane straight from the input, lanes beyond it forced to zero.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < r_idx)
        w_word[8*i +: 8] = r_hold[8*i +: 8];
      else if (2'(i) == r_idx)
        w_word[8*i +: 8] = pix_in;
    end
    case (r_idx)
      2'd0:    w_keep = 4'b0001;
      2'd1:    w_keep = 4'b0011;
      2'd2:    w_keep = 4'b0111;
      default: w_keep = 4'b1111;
    endcase
  end

  // Holding register lanes carry pixel data only, so they are not reset;
  // stale lanes are masked by the lane index during assembly.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_hold[8*r_idx +: 8] <= pix_in;
  end

  // FIFO storage write port (data path, no reset).
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= {r_sof, pix_last, w_keep, w_word};
  end

  // Packing lane index: advances per accepted pixel, restarts on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idx <= 2'd0;
    else if (w_push)
      r_idx <= 2'd0;
    else if (w_accept)
      r_idx <= r_idx + 2'd1;
  end

  // FIFO pointers and fill level; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Frame position: count line ends, re-arm start-of-frame after the last line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_sof  <= 1'b1;
    end else if (w_push) begin
      if (pix_last && (r_line == LAST_LINE)) begin
        r_line <= '0;
        r_sof  <= 1'b1;
      end else begin
        if (pix_last)
          r_line <= r_line + 1'b1;
        r_sof <= 1'b0;
      end
    end
  end

  // Sticky overflow flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (pix_valid && !pix_ready)
      r_ovf <= 1'b1;
    else if (clr_ovf)
      r_ovf <= 1'b0;
  end

  assign ovf = r_ovf;

  // Head entry drives the stream; idle outputs are held at zero.
  assign w_head        = r_mem[r_rd];
  assign m_axis_tvalid = (r_cnt != '0);
  assign m_axis_tdata  = m_axis_tvalid ? w_head[31:0]  : 32'h0;
  assign m_axis_tkeep  = m_axis_tvalid ? w_head[35:32] : 4'h0;
  assign m_axis_tlast  = m_axis_tvalid && w_head[36];
  assign m_axis_tuser  = m_axis_tvalid && w_head[37];

endmodule

// File: tb/tb_edge_axis_packer.sv
module tb_edge_axis_packer;

  localparam int DEPTH = 16;
  localparam int FL    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pix_in = 8'h00;
  logic        pix_valid = 1'b0;
  logic        pix_last = 1'b0;
  logic        pix_ready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        ovf;
  logic        clr_ovf = 1'b0;

  edge_axis_packer #(.DEPTH(DEPTH), .FRAME_LINES(FL)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(pix_ready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: words are {tuser, tlast, tkeep, tdata}
  logic [37:0] q[$];
  logic [7:0]  cur[$];
  logic [37:0] log_w[$];
  bit          m_sof = 1'b1;
  int          m_line = 0;
  bit          m_ovf = 1'b0;
  bit          m_rdy;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] dut_word();
    return {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
  endfunction

  // Behavioural model: a queue of pending words built from the packing rules.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete(); cur.delete();
        m_sof = 1'b1; m_line = 0; m_ovf = 1'b0;
      end else begin
        m_rdy = (q.size() < DEPTH);
        if (m_axis_tvalid && m_axis_tready && q.size() > 0) begin
          log_w.push_back(dut_word());
          void'(q.pop_front());
        end
        if (pix_valid && m_rdy) begin
          cur.push_back(pix_in);
          if (cur.size() == 4 || pix_last) begin
            m_data = '0;
            foreach (cur[i]) m_data[8*i +: 8] = cur[i];
            q.push_back({m_sof, pix_last, 4'((1 << cur.size()) - 1), m_data});
            if (pix_last) begin
              m_line++;
              if (m_line == FL) begin m_line = 0; m_sof = 1'b1; end
              else m_sof = 1'b0;
            end else m_sof = 1'b0;
            cur.delete();
          end
        end
        if (pix_valid && !m_rdy) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
      end
    end
  end

  // Compare process: every out-of-reset cycle, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("tvalid", 38'(m_axis_tvalid), 38'(q.size() != 0));
        chk("pix_ready", 38'(pix_ready), 38'(q.size() < DEPTH));
        chk("ovf", 38'(ovf), 38'(m_ovf));
        if (q.size() != 0) chk("head", dut_word(), q[0]);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic last);
    pix_in = d; pix_valid = 1'b1; pix_last = last;
    @(posedge clk); #1;
    pix_valid = 1'b0; pix_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_axis_tready = 1'b1;
    while (m_axis_tvalid && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_timeout", 38'(m_axis_tvalid), 38'd0);
  endtask

  logic [7:0] t1 [8];
  initial begin
    t1 = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
    // Reset state
    #12;
    chk("rst_tvalid", 38'(m_axis_tvalid), 38'd0);
    chk("rst_outs", dut_word(), 38'd0);
    chk("rst_ready", 38'(pix_ready), 38'd1);
    chk("rst_ovf", 38'(ovf), 38'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two full words, latency of one cycle after the completing accept
    log_w.delete();
    for (int i = 0; i < 8; i++) begin
      send(t1[i], i == 7);
      if (i == 2) chk("lat_before", 38'(m_axis_tvalid), 38'd0);
      if (i == 3) chk("lat_after", 38'(m_axis_tvalid), 38'd1);
    end
    drain();
    chk("t1_w0", log_w[0], {1'b1, 1'b0, 4'hF, 32'h00FFFF00});
    chk("t1_w1", log_w[1], {1'b0, 1'b1, 4'hF, 32'hFF0000FF});

    // Short line tail
    log_w.delete();
    for (int i = 0; i < 6; i++) send(8'hFF, i == 5);
    drain();
    chk("t2_w0", log_w[0], {1'b0, 1'b0, 4'hF, 32'hFFFFFFFF});
    chk("t2_w1", log_w[1], {1'b0, 1'b1, 4'h3, 32'h0000FFFF});

    // Fill the FIFO with backpressure
    log_w.delete();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4 * DEPTH; i++) send(8'(i), 1'b0);
    chk("full_ready", 38'(pix_ready), 38'd0);
    chk("full_valid", 38'(m_axis_tvalid), 38'd1);
    chk("full_head", 38'(m_axis_tdata), 38'h03020100);
    // Drops while full
    pix_in = 8'hAA; pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 pix_valid = 1'b0;
    chk("ovf_set", 38'(ovf), 38'd1);
    chk("drop_head", 38'(m_axis_tdata), 38'h03020100);
    clr_ovf = 1'b1; @(posedge clk); #1 clr_ovf = 1'b0;
    chk("ovf_clr", 38'(ovf), 38'd0);
    m_axis_tready = 1'b1; @(posedge clk); #1 m_axis_tready = 1'b0;
    chk("ready_back", 38'(pix_ready), 38'd1);
    drain();
    for (int k = 0; k < DEPTH; k++)
      chk("order", 38'(log_w[k][31:0]),
          38'({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}));

    // Frame boundaries: restart from reset so the frame begins cleanly
    rst_n = 1'b0; #10; rst_n = 1'b1;
    @(posedge clk); #1;
    log_w.delete();
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 4; i++) send(8'(16*l + i), i == 3);
    drain();
    chk("fr_tuser", 38'({log_w[0][37], log_w[1][37], log_w[2][37]}), 38'b101);
    chk("fr_tlast", 38'({log_w[0][36], log_w[1][36], log_w[2][36]}), 38'b111);

    // Reset mid-word with words queued
    m_axis_tready = 1'b0;
    for (int i = 0; i < 22; i++) send(8'hFF, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", 38'(m_axis_tvalid), 38'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    log_w.delete();
    m_axis_tready = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    drain();
    chk("post_rst_cnt", 38'(log_w.size()), 38'd1);
    if (log_w.size() > 0)
      chk("post_rst_w", log_w[0], {1'b1, 1'b0, 4'hF, 32'h44332211});

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
